// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared widths, opcode fields and fetch entry type for the Tomasulo core
package tomasulo_pkg;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_PC_W    = 32;
    localparam int OPC_MSB     = 15;
    localparam int OPC_LSB     = 12;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_LD  = 4'h3;
    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_PC_W-1:0]    pc;
    } fetch_entry_t;
    function automatic logic [3:0] opcode_of(input logic [DEF_INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction
endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with push/pop/flush and occupancy count
module fetch_fifo
    import tomasulo_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int A = $clog2(DEPTH);
    entry_t mem [DEPTH];
    logic [A-1:0] wr, rd;
    assign head = mem[rd];
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr] <= push_data;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + A'(1);
            if (pop) rd <= rd + A'(1);
            count <= count + (A+1)'(push) - (A+1)'(pop);
        end
    end
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: instruction memory, PC and credit-based prefetch into an issue queue
module instr_fetch_queue
    import tomasulo_pkg::*;
#(
    parameter int INSTR_W   = DEF_INSTR_W,
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = $clog2(MEM_DEPTH),
    parameter int PC_W      = DEF_PC_W,
    parameter int Q_DEPTH   = 4
) (
    input  logic                       clk1,
    input  logic                       rst,
    input  logic                       prog_we,
    input  logic [ADDR_W-1:0]          prog_addr,
    input  logic [INSTR_W-1:0]         prog_data,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [INSTR_W-1:0]         iss_instr,
    output logic [PC_W-1:0]            iss_pc,
    output logic [$clog2(Q_DEPTH):0]   q_count,
    output logic                       fetch_done
);
    localparam int QA = $clog2(Q_DEPTH);
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;
    logic [INSTR_W-1:0] mem [MEM_DEPTH];
    logic [INSTR_W-1:0] rd_data;
    logic [PC_W-1:0] pc, fl_pc;
    logic inflight, pop, launch, pc_ok;
    logic [QA+1:0] occ;
    entry_t head;
    assign pop   = iss_valid & iss_ready;
    assign pc_ok = pc < PC_W'(MEM_DEPTH);
    // occupancy counts the read in flight so a landing never overflows the queue
    assign occ    = {1'b0, q_count} + (QA+2)'(inflight) - (QA+2)'(pop);
    assign launch = fetch_en & pc_ok & ~redirect_valid & (occ < (QA+2)'(Q_DEPTH));
    assign iss_valid  = q_count != '0;
    assign iss_instr  = iss_valid ? head.instr : '0;
    assign iss_pc     = iss_valid ? head.pc : '0;
    assign fetch_done = ~pc_ok & ~inflight;
    always_ff @(posedge clk1) begin
        if (prog_we) mem[prog_addr] <= prog_data;
        if (launch) rd_data <= mem[pc[ADDR_W-1:0]];
    end
    always_ff @(posedge clk1) begin
        if (rst) begin
            pc       <= '0;
            fl_pc    <= '0;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= launch;
            if (launch) begin
                pc    <= pc + PC_W'(1);
                fl_pc <= pc;
            end
        end
    end
    fetch_fifo #(.entry_t(entry_t), .DEPTH(Q_DEPTH)) u_fifo (
        .clk       (clk1),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (inflight),
        .push_data ('{instr: rd_data, pc: fl_pc}),
        .pop       (pop),
        .head      (head),
        .count     (q_count)
    );
endmodule
